vga_pattern_gen: RTL and testbench

Parametrised video timing and test-pattern generator for the Verilator sim top and FPGA bring-up. It produces sync, blanking and data-enable for any raster described by parameters. It also drives a frame-latched selectable test pattern at configurable colour depth. Its outputs feed the sim framebuffer capture or the scaler input in place of a core's video, and it advances only on pixel-clock-enable cycles.

---
 rtl/vga_pattern_gen.sv | 168 ++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - parametrised video timing and frame-latched test-pattern generator
// Optional feature macro: VGA_PATGEN_BORDER_EN (1-pixel white border over the active area)
module vga_pattern_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   COLOR_W  = 8
) (
  input  logic               pclk,
  input  logic               reset_n,
  input  logic               ce_pix,
  input  logic [3:0]         patt_select,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               hs,
  output logic               vs,
  output logic               hblank,
  output logic               vblank,
  output logic               VGA_DE,
  output logic [11:0]        hcount,
  output logic [11:0]        vcount,
  output logic [7:0]         frame_count
);

  localparam logic [11:0] H_ACT     = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_ST = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_EN = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT     = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_ST = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_EN = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST    = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  // Last pixel index inside one colour bar; bar width is H_ACTIVE/8.
  localparam logic [11:0] BW_LAST   = 12'(H_ACTIVE / 8 - 1);
  localparam logic [11:0] BOX       = 12'd32;
  localparam logic [COLOR_W-1:0] FS = '1;

  logic [11:0] h_cnt, v_cnt;
  logic [11:0] bx, by;
  logic [11:0] bar_sub;
  logic [2:0]  bar_idx;
  logic [3:0]  patt_reg;
  logic [7:0]  frame_cnt;

  logic h_wrap, v_wrap, frame_start, active, in_box;
  logic [3:0] cur_patt;
  logic [COLOR_W-1:0] pr, pg, pb;

  assign h_wrap      = (h_cnt == H_LAST);
  assign v_wrap      = (v_cnt == V_LAST);
  assign frame_start = (h_cnt == 12'd0) && (v_cnt == 12'd0);
  assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  // The first pixel of a frame already uses the freshly sampled code.
  assign cur_patt    = frame_start ? patt_select : patt_reg;
  assign in_box      = (h_cnt >= bx) && (h_cnt < bx + BOX) &&
                       (v_cnt >= by) && (v_cnt < by + BOX);

  // Raster counters, frame counter, box origin and pattern latch.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
      bx        <= '0;
      by        <= '0;
      patt_reg  <= '0;
    end else if (ce_pix) begin
      if (frame_start) patt_reg <= patt_select;
      h_cnt <= h_wrap ? 12'd0 : h_cnt + 12'd1;
      if (h_wrap) begin
        v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
        if (v_wrap) begin
          frame_cnt <= frame_cnt + 8'd1;
          // Step the box; restart when the next position would overhang.
          bx <= (bx + BOX + 12'd1 > H_ACT) ? 12'd0 : bx + 12'd1;
          by <= (by + BOX + 12'd1 > V_ACT) ? 12'd0 : by + 12'd1;
        end
      end
    end
  end

  // Colour-bar index tracks h_cnt without a divider; saturates on the black bar.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      bar_sub <= '0;
      bar_idx <= '0;
    end else if (ce_pix) begin
      if (h_wrap) begin
        bar_sub <= '0;
        bar_idx <= '0;
      end else if (bar_sub == BW_LAST) begin
        bar_sub <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_sub <= bar_sub + 12'd1;
      end
    end
  end

  // Pattern colour for the current raster position.
  always_comb begin
    pr = '0;
    pg = '0;
    pb = '0;
    case (cur_patt)
      4'd1: begin pr = FS; pg = FS; pb = FS; end
      4'd2: begin
        pr = {COLOR_W{~bar_idx[1]}};
        pg = {COLOR_W{~bar_idx[2]}};
        pb = {COLOR_W{~bar_idx[0]}};
      end
      4'd3: if (h_cnt[4:0] == 5'd0 || v_cnt[4:0] == 5'd0) begin pr = FS; pg = FS; pb = FS; end
      4'd4: if (h_cnt[5] ^ v_cnt[5]) begin pr = FS; pg = FS; pb = FS; end
      4'd5: begin pr = h_cnt[COLOR_W-1:0]; pg = h_cnt[COLOR_W-1:0]; pb = h_cnt[COLOR_W-1:0]; end
      4'd6: begin pr = v_cnt[COLOR_W-1:0]; pg = v_cnt[COLOR_W-1:0]; pb = v_cnt[COLOR_W-1:0]; end
      4'd7: if (in_box) begin pr = FS; pg = FS; pb = FS; end
      4'd8: pr = FS;
      4'd9: pg = FS;
      4'd10: pb = FS;
      default: ;
    endcase
`ifdef VGA_PATGEN_BORDER_EN
    if (h_cnt == 12'd0 || h_cnt == H_ACT - 12'd1 || v_cnt == 12'd0 || v_cnt == V_ACT - 12'd1) begin
      pr = FS;
      pg = FS;
      pb = FS;
    end
`endif
  end

  // Output stage: one enabled cycle behind the counters, all outputs aligned.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      VGA_DE      <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      frame_count <= '0;
    end else if (ce_pix) begin
      vga_r       <= active ? pr : '0;
      vga_g       <= active ? pg : '0;
      vga_b       <= active ? pb : '0;
      hs          <= (h_cnt >= H_SYNC_ST && h_cnt < H_SYNC_EN) ? HS_POL : ~HS_POL;
      vs          <= (v_cnt >= V_SYNC_ST && v_cnt < V_SYNC_EN) ? VS_POL : ~VS_POL;
      hblank      <= (h_cnt >= H_ACT);
      vblank      <= (v_cnt >= V_ACT);
      VGA_DE      <= active;
      hcount      <= h_cnt;
      vcount      <= v_cnt;
      frame_count <= frame_cnt;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - scoreboard bench for vga_pattern_gen on a reduced raster
module tb_vga_pattern_gen;
  localparam int HA = 66, HF = 4, HSY = 8, HB = 4;
  localparam int VA = 40, VF = 2, VSY = 3, VB = 3;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_pix = 1'b1;
  logic [3:0]  patt_select = 4'd2;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        hs, vs, hblank, vblank, VGA_DE;
  logic [11:0] hcount, vcount;
  logic [7:0]  frame_count;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .ce_pix(ce_pix), .patt_select(patt_select),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hs(hs), .vs(vs), .hblank(hblank), .vblank(vblank), .VGA_DE(VGA_DE),
    .hcount(hcount), .vcount(vcount), .frame_count(frame_count)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    int          h;
    int          v;
    int          fc;
    logic [23:0] rgb;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input int h, input int v, input int fc, input logic [23:0] rgb);
    exp_t e;
    e.name = name; e.h = h; e.v = v; e.fc = fc; e.rgb = rgb;
`ifdef VGA_PATGEN_BORDER_EN
    if (h < HA && v < VA && (h == 0 || h == HA - 1 || v == 0 || v == VA - 1)) e.rgb = 24'hFFFFFF;
`endif
    sb.push_back(e);
  endtask

  task automatic wait_sb(input int bound);
    int n;
    exp_t e;
    n = 0;
    while (sb.size() > 0 && n < bound) begin
      @(posedge pclk);
      n++;
    end
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      n_err++;
      $display("FAIL %s: pixel (%0d,%0d) frame %0d never presented, expected rgb %06h", e.name, e.h, e.v, e.fc, e.rgb);
    end
  endtask

  task automatic set_patt(input logic [3:0] p);
    @(negedge pclk);
    patt_select = p;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    check({tag, "_hs"}, hs, 1);
    check({tag, "_vs"}, vs, 1);
    check({tag, "_hblank"}, hblank, 1);
    check({tag, "_vblank"}, vblank, 1);
    check({tag, "_de"}, VGA_DE, 0);
    check({tag, "_hcount"}, hcount, 0);
    check({tag, "_vcount"}, vcount, 0);
    check({tag, "_frame"}, frame_count, 0);
  endtask

  // Monitor: whenever an enabled edge presents the queued pixel, compare its colour.
  always @(posedge pclk) begin : monitor
    logic en;
    exp_t e;
    en = ce_pix & reset_n;
    #1;
    if (en && sb.size() > 0 && int'(hcount) == sb[0].h && int'(vcount) == sb[0].v &&
        int'(frame_count) == sb[0].fc) begin
      e = sb.pop_front();
      check(e.name, {vga_r, vga_g, vga_b}, e.rgb);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int de_n, hs_n, hs_bad, vs_n, vs_bad, bl_bad, line_per;
    int k_first, k_second, changed, found, seen00;
    logic en;
    logic [60:0] prev, cur;

    repeat (3) @(posedge pclk);
    #1;
    check_reset("reset");

    // Frame 0: colour bars, including the remainder pixel and a blanked pixel.
    push("bar_origin", 0, 0, 0, 24'hFFFFFF);
    push("bar_white", 7, 10, 0, 24'hFFFFFF);
    push("bar_yellow", 8, 10, 0, 24'hFFFF00);
    push("bar_cyan", 16, 10, 0, 24'h00FFFF);
    push("bar_green", 24, 10, 0, 24'h00FF00);
    push("bar_magenta", 32, 10, 0, 24'hFF00FF);
    push("bar_red", 40, 10, 0, 24'hFF0000);
    push("bar_blue", 55, 10, 0, 24'h0000FF);
    push("bar_black", 56, 10, 0, 24'h000000);
    push("bar_remainder", 64, 10, 0, 24'h000000);
    push("bar_hblank", 70, 10, 0, 24'h000000);
    @(negedge pclk);
    reset_n = 1'b1;

    de_n = 0; hs_n = 0; hs_bad = 0; vs_n = 0; vs_bad = 0; bl_bad = 0; line_per = -1;
    for (int n = 0; n <= FT; n++) begin
      @(posedge pclk);
      #1;
      if (n == 0) begin
        check("first_hcount", hcount, 0);
        check("first_vcount", vcount, 0);
      end else if (n == FT) begin
        check("frame_period_h", hcount, 0);
        check("frame_period_v", vcount, 0);
        check("frame_count_1", frame_count, 1);
      end
      if (n < FT) begin
        if (VGA_DE) de_n++;
        if (!hs) begin
          hs_n++;
          if (hcount < HA + HF || hcount >= HA + HF + HSY) hs_bad++;
        end
        if (!vs) begin
          vs_n++;
          if (vcount < VA + VF || vcount >= VA + VF + VSY) vs_bad++;
        end
        if (hblank != (hcount >= HA) || vblank != (vcount >= VA) ||
            VGA_DE != (hcount < HA && vcount < VA)) bl_bad++;
        if (n > 0 && hcount == 0 && line_per < 0) line_per = n;
      end
    end
    check("de_count", de_n, HA * VA);
    check("hs_low_count", hs_n, HSY * VT);
    check("hs_window", hs_bad, 0);
    check("vs_low_count", vs_n, VSY * HT);
    check("vs_window", vs_bad, 0);
    check("blank_flags", bl_bad, 0);
    check("line_period", line_per, HT);
    wait_sb(FT);

    // Pattern change mid-frame takes effect only at the next frame.
    set_patt(4'd1);
    push("white_origin", 0, 0, 2, 24'hFFFFFF);
    push("white_10_20", 10, 20, 2, 24'hFFFFFF);
    push("hold_5_25", 5, 25, 2, 24'hFFFFFF);
    push("hold_last", 65, 39, 2, 24'hFFFFFF);
    push("new_origin", 0, 0, 3, 24'h000000);
    push("new_5_5", 5, 5, 3, 24'h000000);
    found = 0;
    for (int n = 0; n < 3 * FT && found == 0; n++) begin
      @(posedge pclk);
      #1;
      if (frame_count == 2 && vcount == 20) found = 1;
    end
    check("reach_line20", found, 1);
    set_patt(4'd0);
    wait_sb(4 * FT);

    set_patt(4'd3);
    push("grid_origin", 0, 0, 4, 24'hFFFFFF);
    push("grid_off", 5, 5, 4, 24'h000000);
    push("grid_col", 32, 5, 4, 24'hFFFFFF);
    push("grid_row", 5, 32, 4, 24'hFFFFFF);
    push("grid_off2", 33, 33, 4, 24'h000000);
    wait_sb(4 * FT);

    set_patt(4'd4);
    push("chk_origin", 0, 0, 5, 24'h000000);
    push("chk_h", 32, 5, 5, 24'hFFFFFF);
    push("chk_v", 5, 32, 5, 24'hFFFFFF);
    push("chk_hv", 33, 33, 5, 24'h000000);
    wait_sb(4 * FT);

    set_patt(4'd5);
    push("hgrad_origin", 0, 0, 6, 24'h000000);
    push("hgrad_37", 37, 3, 6, 24'h252525);
    push("hgrad_65", 65, 3, 6, 24'h414141);
    wait_sb(4 * FT);

    set_patt(4'd6);
    push("vgrad_17", 10, 17, 7, 24'h111111);
    push("vgrad_39", 10, 39, 7, 24'h272727);
    wait_sb(4 * FT);

    // Moving box: origin (8,8) in frame 8; by wraps to 0 in frame 9, bx reaches 9.
    set_patt(4'd7);
    push("box8_above", 8, 7, 8, 24'h000000);
    push("box8_left", 7, 8, 8, 24'h000000);
    push("box8_origin", 8, 8, 8, 24'hFFFFFF);
    push("box8_right", 40, 10, 8, 24'h000000);
    push("box8_corner", 39, 39, 8, 24'hFFFFFF);
    push("box9_left", 8, 0, 9, 24'h000000);
    push("box9_origin", 9, 0, 9, 24'hFFFFFF);
    push("box9_corner", 40, 31, 9, 24'hFFFFFF);
    push("box9_right", 41, 31, 9, 24'h000000);
    push("box9_below", 9, 32, 9, 24'h000000);
    wait_sb(4 * FT);

    set_patt(4'd8);
    push("red", 3, 3, 10, 24'hFF0000);
    wait_sb(4 * FT);
    set_patt(4'd9);
    push("green", 3, 3, 11, 24'h00FF00);
    wait_sb(4 * FT);
    set_patt(4'd10);
    push("blue", 3, 3, 12, 24'h0000FF);
    wait_sb(4 * FT);
    set_patt(4'd0);
    push("black_origin", 0, 0, 13, 24'h000000);
    push("black_1_1", 1, 1, 13, 24'h000000);
    push("black_last", 65, 39, 13, 24'h000000);
    wait_sb(4 * FT);

    // Pixel enable one cycle in four.
    set_patt(4'd1);
    k_first = -1; k_second = -1; changed = 0; prev = '0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge pclk);
      ce_pix = (k % 4 == 0);
      @(posedge pclk);
      en = ce_pix;
      #1;
      cur = {vga_r, vga_g, vga_b, hs, vs, hblank, vblank, VGA_DE, hcount, vcount, frame_count};
      if (k > 0 && !en && cur != prev) changed++;
      if (en && hcount == 0) begin
        if (k_first < 0) k_first = k;
        else if (k_second < 0) k_second = k;
      end
      prev = cur;
    end
    check("ce_line_period", k_second - k_first, 4 * HT);
    check("ce_hold", changed, 0);
    @(negedge pclk);
    ce_pix = 1'b1;

    // Reset mid-frame at (30,20) of a white frame.
    found = 0; seen00 = 0;
    for (int n = 0; n < 3 * FT && found == 0; n++) begin
      @(posedge pclk);
      #1;
      if (hcount == 0 && vcount == 0) seen00 = 1;
      if (seen00 == 1 && hcount == 30 && vcount == 20) found = 1;
    end
    check("reach_reset_point", found, 1);
    check("pre_reset_white", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
    reset_n = 1'b0;
    #1;
    check_reset("rst_async");
    repeat (3) @(posedge pclk);
    #1;
    check_reset("rst_hold");
    patt_select = 4'd8;
    push("restart_origin", 0, 0, 0, 24'hFF0000);
    push("restart_4_4", 4, 4, 0, 24'hFF0000);
    @(negedge pclk);
    reset_n = 1'b1;
    @(posedge pclk);
    #1;
    check("restart_hcount", hcount, 0);
    check("restart_vcount", vcount, 0);
    check("restart_frame", frame_count, 0);
    wait_sb(2 * FT);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
